exc_ctrl: RTL and testbench
===========================

Name: exc_ctrl

Overview:
- Exception/interrupt sequencer for the single-cycle LEGv8 core.
- Drives the fetch stage's exception redirect pair (EProc_F, EVAddr_F), which overrides the normal next-PC selection at the next clock edge.
- Tracks handler state and holds the return address (ELR) and the syndrome (ESR).
- Arbitrates between synchronous exceptions from decode, a latched external interrupt, ERET, and double faults.

Parameters:
- N, 64, datapath/address width.
- VBAR, 64'h0000_0000_0000_1000, vector base address. Sync vector = VBAR+0x000, IRQ vector = VBAR+0x080, double-fault vector = VBAR+0x100.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- Exc_D  in  1  synchronous exception raised by the current instruction.
- ExcCode_D  in  4  cause code accompanying Exc_D.
- ERet_D  in  1  current instruction is ERET.
- ExtIRQ_in  in  1  external interrupt request; a 1 in any cycle sets the pending latch.
- PC_F  in  N  address of the current instruction.
- NextPC_F  in  N  normal next PC (sequential or branch).
- EProc_F  out  1  redirect fetch this cycle.
- EVAddr_F  out  N  redirect target.
- ELR_out  out  N  exception link register.
- ESR_out  out  6  syndrome: [5:4] type (00 none, 01 sync, 10 irq, 11 dfault), [3:0] code.
- InHandler_out  out  1  high while state != RUN.
- IRQAck_out  out  1  high in the cycle an IRQ is taken.
- ECount_out  out  8  number of taken exceptions/IRQs; saturates at 255.

Behaviour:
- States: RUN, HANDLER, DFAULT.
- Reset (reset=0, asynchronous): state=RUN, ELR=0, ESR=0, irq_pend=0, ECount=0. Combinational outputs are forced low while reset=0.
- EProc_F, EVAddr_F and IRQAck_out are combinational from state, irq_pend and inputs. Zero-cycle latency: the PC takes the target at the next edge.
- irq_pend: set when ExtIRQ_in=1. Cleared at the edge where an IRQ is taken. Set wins over clear only if ExtIRQ_in is still 1 in the take cycle.

RUN, priority order:
1. Exc_D: EProc_F=1, EVAddr_F=VBAR. At the edge: ELR<=PC_F, ESR<={01,ExcCode_D}, state<=HANDLER.
2. ERet_D (illegal in RUN): handled as sync with code 4'hF; same ELR/ESR/state updates.
3. irq_pend: EProc_F=1, EVAddr_F=VBAR+0x80, IRQAck_out=1. At the edge: ELR<=NextPC_F, ESR<={10,0000}, state<=HANDLER, irq_pend<=0.
4. Otherwise: EProc_F=0, EVAddr_F=0.

HANDLER:
- IRQs are masked; irq_pend keeps accumulating.
- Exc_D: EProc_F=1, EVAddr_F=VBAR+0x100. At the edge: ESR<={11,ExcCode_D}, ELR unchanged, state<=DFAULT.
- ERet_D (and Exc_D=0): EProc_F=1, EVAddr_F=ELR. At the edge: state<=RUN; ESR retained.
- A pending IRQ is taken in the first RUN cycle after ERET; ELR<=NextPC_F of that cycle.

DFAULT:
- Terminal state; EProc_F=0; ERet_D, Exc_D and IRQ are ignored. Exit only via reset.

ECount: increments by 1 at every edge where a RUN or HANDLER redirect other than ERET occurs. Holds at 255.

Simultaneous events:
- Exc_D + ERet_D: Exc_D wins.
- Exc_D + irq_pend in RUN: sync is taken and the IRQ stays pending.
- Reset asserted mid-handler: returns to RUN immediately and discards all state.

Address arithmetic: N-bit modulo 2^N; no overflow detection.

Test Plan:
- Sync exception: RUN, PC_F=0x40, Exc_D=1, ExcCode_D=3 -> same cycle EProc_F=1, EVAddr_F=0x1000. Next cycle ELR=0x40, ESR=0x13, InHandler=1, ECount=1.
- IRQ: 1-cycle ExtIRQ_in pulse with NextPC_F=0x84 while idle -> next cycle IRQAck=1, EVAddr_F=0x1080. Afterwards ELR=0x84, ESR=0x20, irq_pend=0.
- ERET with queued IRQ: pulse ExtIRQ_in during HANDLER (ELR=0x40) -> no IRQAck while in HANDLER. ERet_D=1 -> EVAddr_F=0x40, state=RUN. Next cycle IRQAck=1, EVAddr_F=0x1080.
- Double fault: in HANDLER with ELR=0x40, Exc_D=1, ExcCode_D=5 -> EVAddr_F=0x1100, ESR=0x35, ELR=0x40. Afterwards ERet_D=1 -> EProc_F=0, state stays DFAULT.
- Priority and illegal ERET: RUN, Exc_D=1 and ERet_D=1 with irq_pend=1 -> ESR={01,code}, irq_pend still 1. RUN with ERet_D alone -> ESR=0x1F, EVAddr_F=0x1000.
- Reset/saturation: drive reset low mid-HANDLER -> all outputs 0 immediately. Force 260 exceptions/ERETs -> ECount_out=255.

Source files
------------

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer for the single-cycle LEGv8 core: drives the fetch
// redirect pair, tracks handler state and holds ELR/ESR plus a saturating exception count.
module exc_ctrl #(
    parameter int           N    = 64,
    parameter logic [N-1:0] VBAR = N'(64'h0000_0000_0000_1000)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         Exc_D,
    input  logic [3:0]   ExcCode_D,
    input  logic         ERet_D,
    input  logic         ExtIRQ_in,
    input  logic [N-1:0] PC_F,
    input  logic [N-1:0] NextPC_F,
    output logic         EProc_F,
    output logic [N-1:0] EVAddr_F,
    output logic [N-1:0] ELR_out,
    output logic [5:0]   ESR_out,
    output logic         InHandler_out,
    output logic         IRQAck_out,
    output logic [7:0]   ECount_out
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HANDLER = 2'd1,
        DFAULT  = 2'd2
    } state_t;

    state_t       state_q;
    logic [N-1:0] elr_q;
    logic [5:0]   esr_q;
    logic         irq_pend_q;
    logic [7:0]   ecount_q;

    logic take_sync, take_irq, take_df, take_ret;
    logic eproc_d, irqack_d;
    logic [N-1:0] evaddr_d;

    // Redirect decision is combinational so the PC picks up the target at the next edge.
    always_comb begin
        take_sync = 1'b0;
        take_irq  = 1'b0;
        take_df   = 1'b0;
        take_ret  = 1'b0;
        eproc_d   = 1'b0;
        irqack_d  = 1'b0;
        evaddr_d  = '0;
        if (reset) begin
            unique case (state_q)
                RUN: begin
                    if (Exc_D || ERet_D) begin
                        take_sync = 1'b1;
                        eproc_d   = 1'b1;
                        evaddr_d  = VBAR;
                    end else if (irq_pend_q) begin
                        take_irq  = 1'b1;
                        eproc_d   = 1'b1;
                        irqack_d  = 1'b1;
                        evaddr_d  = VBAR + N'(12'h080);
                    end
                end
                HANDLER: begin
                    if (Exc_D) begin
                        take_df  = 1'b1;
                        eproc_d  = 1'b1;
                        evaddr_d = VBAR + N'(12'h100);
                    end else if (ERet_D) begin
                        take_ret = 1'b1;
                        eproc_d  = 1'b1;
                        evaddr_d = elr_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            elr_q      <= '0;
            esr_q      <= '0;
            irq_pend_q <= 1'b0;
            ecount_q   <= '0;
        end else begin
            // A request arriving in the take cycle survives the clear.
            irq_pend_q <= ExtIRQ_in | (irq_pend_q & ~take_irq);
            if (take_sync) begin
                state_q <= HANDLER;
                elr_q   <= PC_F;
                esr_q   <= {2'b01, (Exc_D ? ExcCode_D : 4'hF)};
            end else if (take_irq) begin
                state_q <= HANDLER;
                elr_q   <= NextPC_F;
                esr_q   <= 6'b10_0000;
            end else if (take_df) begin
                state_q <= DFAULT;
                esr_q   <= {2'b11, ExcCode_D};
            end else if (take_ret) begin
                state_q <= RUN;
            end
            if ((take_sync || take_irq || take_df) && ecount_q != 8'hFF)
                ecount_q <= ecount_q + 8'd1;
        end
    end

    assign EProc_F       = eproc_d;
    assign EVAddr_F      = evaddr_d;
    assign IRQAck_out    = irqack_d;
    assign ELR_out       = elr_q;
    assign ESR_out       = esr_q;
    assign InHandler_out = (state_q != RUN);
    assign ECount_out    = ecount_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: sync/IRQ/ERET/double-fault sequencing, priority, reset and saturation.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        Exc_D;
    logic [3:0]  ExcCode_D;
    logic        ERet_D;
    logic        ExtIRQ_in;
    logic [63:0] PC_F;
    logic [63:0] NextPC_F;
    logic        EProc_F;
    logic [63:0] EVAddr_F;
    logic [63:0] ELR_out;
    logic [5:0]  ESR_out;
    logic        InHandler_out;
    logic        IRQAck_out;
    logic [7:0]  ECount_out;

    int errors = 0;
    int checks = 0;

    exc_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .Exc_D        (Exc_D),
        .ExcCode_D    (ExcCode_D),
        .ERet_D       (ERet_D),
        .ExtIRQ_in    (ExtIRQ_in),
        .PC_F         (PC_F),
        .NextPC_F     (NextPC_F),
        .EProc_F      (EProc_F),
        .EVAddr_F     (EVAddr_F),
        .ELR_out      (ELR_out),
        .ESR_out      (ESR_out),
        .InHandler_out(InHandler_out),
        .IRQAck_out   (IRQAck_out),
        .ECount_out   (ECount_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Exc_D = 1'b0; ExcCode_D = 4'h0; ERet_D = 1'b0; ExtIRQ_in = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        PC_F = 64'h0; NextPC_F = 64'h0;
        #12;
        chk("rst_eproc",  64'(EProc_F), 64'h0);
        chk("rst_evaddr", EVAddr_F, 64'h0);
        chk("rst_elr",    ELR_out, 64'h0);
        chk("rst_esr",    64'(ESR_out), 64'h0);
        chk("rst_inh",    64'(InHandler_out), 64'h0);
        chk("rst_cnt",    64'(ECount_out), 64'h0);
        reset = 1'b1;
        tick();
        chk("idle_eproc", 64'(EProc_F), 64'h0);

        // Synchronous exception from RUN
        PC_F = 64'h40; Exc_D = 1'b1; ExcCode_D = 4'h3; #1;
        chk("sync_eproc",  64'(EProc_F), 64'h1);
        chk("sync_evaddr", EVAddr_F, 64'h1000);
        chk("sync_ack",    64'(IRQAck_out), 64'h0);
        tick(); idle_inputs();
        chk("sync_elr", ELR_out, 64'h40);
        chk("sync_esr", 64'(ESR_out), 64'h13);
        chk("sync_inh", 64'(InHandler_out), 64'h1);
        chk("sync_cnt", 64'(ECount_out), 64'h1);

        // IRQ pulse while in HANDLER stays masked
        ExtIRQ_in = 1'b1; #1;
        chk("mask_ack0",   64'(IRQAck_out), 64'h0);
        chk("mask_eproc0", 64'(EProc_F), 64'h0);
        tick(); idle_inputs(); #1;
        chk("mask_ack1", 64'(IRQAck_out), 64'h0);
        ERet_D = 1'b1; #1;
        chk("eret_eproc",  64'(EProc_F), 64'h1);
        chk("eret_evaddr", EVAddr_F, 64'h40);
        chk("eret_ack",    64'(IRQAck_out), 64'h0);
        tick(); idle_inputs(); NextPC_F = 64'h84; #1;
        chk("eret_inh",  64'(InHandler_out), 64'h0);
        chk("eret_cnt",  64'(ECount_out), 64'h1);
        chk("qirq_ack",    64'(IRQAck_out), 64'h1);
        chk("qirq_evaddr", EVAddr_F, 64'h1080);
        tick();
        chk("qirq_elr", ELR_out, 64'h84);
        chk("qirq_esr", 64'(ESR_out), 64'h20);
        chk("qirq_cnt", 64'(ECount_out), 64'h2);
        ERet_D = 1'b1; #1;
        chk("ret2_evaddr", EVAddr_F, 64'h84);
        tick(); idle_inputs(); #1;
        chk("pend_clr_eproc", 64'(EProc_F), 64'h0);
        chk("pend_clr_ack",   64'(IRQAck_out), 64'h0);

        // IRQ from idle: pulse, then taken next cycle
        ExtIRQ_in = 1'b1; NextPC_F = 64'h84; #1;
        chk("irq_pulse_eproc", 64'(EProc_F), 64'h0);
        tick(); idle_inputs(); #1;
        chk("irq_ack",    64'(IRQAck_out), 64'h1);
        chk("irq_evaddr", EVAddr_F, 64'h1080);
        tick();
        chk("irq_elr", ELR_out, 64'h84);
        chk("irq_esr", 64'(ESR_out), 64'h20);
        chk("irq_cnt", 64'(ECount_out), 64'h3);
        ERet_D = 1'b1; tick(); idle_inputs(); #1;
        chk("irq_pend_gone", 64'(IRQAck_out), 64'h0);

        // Double fault
        PC_F = 64'h40; Exc_D = 1'b1; ExcCode_D = 4'h3; tick(); idle_inputs();
        Exc_D = 1'b1; ExcCode_D = 4'h5; #1;
        chk("df_evaddr", EVAddr_F, 64'h1100);
        chk("df_eproc",  64'(EProc_F), 64'h1);
        tick(); idle_inputs();
        chk("df_esr", 64'(ESR_out), 64'h35);
        chk("df_elr", ELR_out, 64'h40);
        chk("df_cnt", 64'(ECount_out), 64'h5);
        ERet_D = 1'b1; ExtIRQ_in = 1'b1; #1;
        chk("df_eret_eproc", 64'(EProc_F), 64'h0);
        tick(); idle_inputs(); Exc_D = 1'b1; #1;
        chk("df_stay_inh",  64'(InHandler_out), 64'h1);
        chk("df_exc_eproc", 64'(EProc_F), 64'h0);
        chk("df_irq_ack",   64'(IRQAck_out), 64'h0);
        tick();
        chk("df_stay_cnt", 64'(ECount_out), 64'h5);

        // Asynchronous reset mid-cycle
        #2; reset = 1'b0; #1;
        chk("arst_eproc", 64'(EProc_F), 64'h0);
        chk("arst_elr",   ELR_out, 64'h0);
        chk("arst_esr",   64'(ESR_out), 64'h0);
        chk("arst_inh",   64'(InHandler_out), 64'h0);
        chk("arst_cnt",   64'(ECount_out), 64'h0);
        idle_inputs();
        @(negedge clk); reset = 1'b1;
        tick(); #1;
        chk("arst_pend_gone", 64'(IRQAck_out), 64'h0);

        // Priority: Exc_D + ERet_D with IRQ pending; set-wins on the take cycle
        ExtIRQ_in = 1'b1; tick(); idle_inputs();
        PC_F = 64'h200; Exc_D = 1'b1; ERet_D = 1'b1; ExcCode_D = 4'h7; #1;
        chk("pri_evaddr", EVAddr_F, 64'h1000);
        chk("pri_ack",    64'(IRQAck_out), 64'h0);
        tick(); idle_inputs();
        chk("pri_esr", 64'(ESR_out), 64'h17);
        chk("pri_elr", ELR_out, 64'h200);
        ERet_D = 1'b1; tick(); idle_inputs();
        NextPC_F = 64'h300; ExtIRQ_in = 1'b1; #1;
        chk("pri_pend_ack", 64'(IRQAck_out), 64'h1);
        tick(); idle_inputs();
        chk("pri_irq_elr", ELR_out, 64'h300);
        chk("pri_irq_esr", 64'(ESR_out), 64'h20);
        chk("pri_irq_cnt", 64'(ECount_out), 64'h2);
        ERet_D = 1'b1; tick(); idle_inputs(); NextPC_F = 64'h340; #1;
        chk("setwin_ack", 64'(IRQAck_out), 64'h1);
        tick();
        chk("setwin_elr", ELR_out, 64'h340);
        ERet_D = 1'b1; tick(); idle_inputs();

        // Illegal ERET in RUN
        PC_F = 64'h500; ERet_D = 1'b1; #1;
        chk("ileret_eproc",  64'(EProc_F), 64'h1);
        chk("ileret_evaddr", EVAddr_F, 64'h1000);
        tick(); idle_inputs();
        chk("ileret_esr", 64'(ESR_out), 64'h1F);
        chk("ileret_elr", ELR_out, 64'h500);
        chk("ileret_cnt", 64'(ECount_out), 64'h4);

        // Saturation: 260 ERET/exception pairs from HANDLER
        for (int i = 0; i < 260; i++) begin
            ERet_D = 1'b1; tick(); idle_inputs();
            Exc_D = 1'b1; tick(); idle_inputs();
        end
        chk("sat_cnt", 64'(ECount_out), 64'hFF);
        ERet_D = 1'b1; tick(); idle_inputs();
        Exc_D = 1'b1; tick(); idle_inputs();
        chk("sat_hold", 64'(ECount_out), 64'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
